spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Receive-side companion to the LIF neuron: consumes a neuron's 1-bit spike output and decodes it back into numbers. It counts spike onsets over a programmable window of clock cycles and reports the count as a rate. It also measures the inter-spike interval (ISI) between consecutive onsets. It sits in the top-level wrapper between a neuron's spike pin and the dedicated outputs or bidirectional pins.

## Interface
Parameters:
- CNT_W, 8, width of the spike counter and `rate_out`
- ISI_W, 8, width of the interval counter and `isi_out`

Ports:
- clk  in  1  clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; 1 starts and continues windows, 0 aborts
- spike_in  in  1  spike level from a neuron; may stay high for several cycles
- window_len  in  8  window length in cycles; 0 means 256; sampled only at window start
- rate_out  out  CNT_W  spike-onset count of the last completed window
- rate_valid  out  1  one-cycle pulse when `rate_out` updates
- rate_sat  out  1  last completed window's count saturated; updates with `rate_valid`
- isi_out  out  ISI_W  last measured inter-spike interval, in cycles
- isi_valid  out  1  one-cycle pulse when `isi_out` updates
- busy  out  1  1 while in RUN

## Operation
- Onset detect: `spike_d` register holds the previous cycle's `spike_in`; `edge = spike_in & ~spike_d` (combinational). A level held high yields one onset only. `spike_d` is cleared by reset.
- FSM states: IDLE, RUN.
  - IDLE, en=1: go to RUN. Load the 9-bit `win_cnt` from `window_len` (0 loads 256). Clear `spike_cnt`, `sat`, `isi_cnt` and `armed`.
  - RUN: `win_cnt` decrements every cycle. Each `edge` increments `spike_cnt`.
  - `spike_cnt` saturates at 2^CNT_W-1. An onset while saturated sets `sat`.
- Window end: the RUN cycle with `win_cnt==1` is the last cycle of the window; an onset in that cycle belongs to this window.
  - Next cycle: `rate_out` = final saturating count, `rate_sat` = final `sat`, `rate_valid`=1 for one cycle.
  - If `en`=1 in the last cycle: `win_cnt` reloads from the current `window_len`, `spike_cnt`/`sat` clear, RUN continues with no gap cycle.
  - If `en`=0 in the last cycle: the result is still reported, then the FSM goes to IDLE.
- Abort: `en`=0 in any non-last RUN cycle drops to IDLE next cycle. The partial count is discarded, no `rate_valid`, `rate_out` holds its old value.
- ISI (RUN only):
  - On `edge`: if `armed`, then `isi_out` <= `isi_cnt` and `isi_valid` pulses next cycle. In either case `armed` <= 1 and `isi_cnt` <= 1.
  - Otherwise, once `armed`, `isi_cnt` increments each cycle, saturating at 2^ISI_W-1.
  - The first onset after entering RUN only arms the measurement. The ISI measurement spans window boundaries and is cleared on entry to RUN from IDLE.
- Reset (any state, including mid-window): FSM to IDLE. `rate_out`, `rate_sat`, `isi_out`, `rate_valid`, `isi_valid`, `busy`, `spike_d` and all counters go to 0.

## Timing
- RUN cycle 0 is the first cycle with `busy`=1, i.e. the cycle after IDLE sees `en`=1.
- A window covers RUN cycles 0..N-1. `rate_valid` is high in cycle N, and cycle N is also cycle 0 of the next window when back-to-back.
- Onset latency: `spike_in` rising in cycle t is counted in cycle t's window. It appears in `rate_out` at the window-end pulse.
- `isi_valid` is high the cycle after the second and later onsets. For onsets in cycles a and b, `isi_out = b-a` (saturated).
- `rate_valid` and `isi_valid` may assert in the same cycle; they are independent.
- `window_len` changes mid-window have no effect until the next window start.

## Test plan
- Reset: assert `rst` 2 cycles with `en`=1 and `spike_in` toggling -> all outputs 0, `busy`=0. After `rst` drops, `busy`=1 one cycle later.
- Basic rate: `window_len`=10, 1-cycle spikes at RUN cycles 0,3,6,9 -> `rate_out`=4, `rate_valid` only in cycle 10, `rate_sat`=0. Same pattern repeated -> second pulse at cycle 20 with 4.
- Held level: `window_len`=10, `spike_in` high for cycles 0-19 -> `rate_out`=1 at cycle 10, then `rate_out`=0 at cycle 20.
- ISI: onsets at RUN cycles 2 and 7, then 300 cycles later (ISI_W=8) -> no `isi_valid` after cycle 2; `isi_out`=5 with `isi_valid` in cycle 8; then `isi_out`=255.
- Saturation: CNT_W=4, `window_len`=0, `spike_in` high on even cycles (128 onsets) -> `rate_valid` at cycle 256, `rate_out`=15, `rate_sat`=1.
- Abort/reset mid-window: `window_len`=10, `en` low in cycle 5 -> IDLE at cycle 6, no `rate_valid`, `rate_out` unchanged. Repeat with `rst` in cycle 5 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike rate / inter-spike-interval decoder: counts spike onsets over a
// programmable window and measures the cycle distance between onsets.
//
// state | meaning
// IDLE  | waiting for en; outputs hold last results
// RUN   | window counting active; busy=1
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [7:0]       window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic             spike_d;
  logic             spike_edge;
  logic [8:0]       win_cnt;
  logic [8:0]       win_load;
  logic             last_cyc;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_full;
  logic             sat;
  logic             sat_nxt;
  logic [ISI_W-1:0] isi_cnt;
  logic             isi_full;
  logic             armed;

  assign spike_edge = spike_in & ~spike_d;
  assign last_cyc   = (win_cnt == 9'd1);
  assign win_load   = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
  assign cnt_full   = &spike_cnt;
  assign isi_full   = &isi_cnt;
  assign cnt_nxt    = spike_cnt + CNT_W'(spike_edge & ~cnt_full);
  assign sat_nxt    = sat | (spike_edge & cnt_full);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // en=0 leaves RUN both on abort and after a final window; the datapath
  // decides whether a result gets reported.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    if (state == IDLE) begin
      if (en) state_nxt = RUN;
    end else begin
      busy = 1'b1;
      if (!en) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_d    <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      sat        <= 1'b0;
      isi_cnt    <= '0;
      armed      <= 1'b0;
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
    end else begin
      spike_d    <= spike_in;
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (state == IDLE) begin
        if (en) begin
          win_cnt   <= win_load;
          spike_cnt <= '0;
          sat       <= 1'b0;
          isi_cnt   <= '0;
          armed     <= 1'b0;
        end
      end else begin
        if (last_cyc) begin
          rate_out   <= cnt_nxt;
          rate_sat   <= sat_nxt;
          rate_valid <= 1'b1;
          win_cnt    <= win_load;
          spike_cnt  <= '0;
          sat        <= 1'b0;
        end else begin
          win_cnt   <= win_cnt - 9'd1;
          spike_cnt <= cnt_nxt;
          sat       <= sat_nxt;
        end

        // The interval keeps running across window boundaries.
        if (spike_edge) begin
          if (armed) begin
            isi_out   <= isi_cnt;
            isi_valid <= 1'b1;
          end
          armed   <= 1'b1;
          isi_cnt <= ISI_W'(1);
        end else if (armed && !isi_full) begin
          isi_cnt <= isi_cnt + ISI_W'(1);
        end
      end
    end
  end

endmodule
